// File: rtl/mem_protect_unit_if.sv
// Request/response bus of mem_protect_unit: the requester drives through
// master, the protection unit answers through slave.
interface mem_protect_unit_if #(
  parameter int ADDR_W = 16
);
  logic              ReqValid;
  logic              ReqReady;
  logic [ADDR_W-1:0] ReqAddr;
  logic              ReqWrite;
  logic [ADDR_W-1:0] SP;
  logic              RespValid;
  logic              RespFault;
  logic [1:0]        RespCause;

  modport master (
    output ReqValid, ReqAddr, ReqWrite, SP,
    input  ReqReady, RespValid, RespFault, RespCause
  );

  modport slave (
    input  ReqValid, ReqAddr, ReqWrite, SP,
    output ReqReady, RespValid, RespFault, RespCause
  );
endinterface

// File: rtl/mem_protect_unit.sv
// Region-table memory protection unit with stack guard and sticky fault latch.
// Optional define MPU_FAULT_COUNT_EN adds an 8-bit saturating FaultCount output.
module mem_protect_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                NUM_REGIONS = 4,
  parameter logic [ADDR_W-1:0] STACK_LO    = 16'hC000,
  parameter logic [ADDR_W-1:0] STACK_HI    = 16'hFFFF,
  localparam int               IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              CfgWe,
  input  logic [IDX_W-1:0]  CfgIdx,
  input  logic [ADDR_W-1:0] CfgBase,
  input  logic [ADDR_W-1:0] CfgLimit,
  input  logic [1:0]        CfgPerm,
  mem_protect_unit_if.slave bus,
  output logic              FaultPending,
  output logic [ADDR_W-1:0] FaultAddr,
  output logic [1:0]        FaultCause,
  input  logic              FaultAck
`ifdef MPU_FAULT_COUNT_EN
  ,
  output logic [7:0]        FaultCount
`endif
);

  typedef enum logic [1:0] {
    CAUSE_OK       = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_PERM     = 2'b10,
    CAUSE_STACK    = 2'b11
  } cause_e;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] STACK_SPAN = STACK_HI - STACK_LO;

  // Region table
  logic [ADDR_W-1:0] base_q  [NUM_REGIONS];
  logic [ADDR_W-1:0] limit_q [NUM_REGIONS];
  logic [1:0]        perm_q  [NUM_REGIONS];

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; this is what makes a same-cycle request see the old table.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) perm_q[i] <= 2'b00;
    end else if (CfgWe) begin
      perm_q[CfgIdx] <= CfgPerm;
    end
  end

  // NOTE: base/limit storage has no reset; a region is only ever consulted
  // through its perm bits, which are cleared on reset, so stale bounds are inert.
  always_ff @(posedge CLK) begin
    if (CfgWe) begin
      base_q[CfgIdx]  <= CfgBase;
      limit_q[CfgIdx] <= CfgLimit;
    end
  end

  // Region lookup: scanning from the top down leaves the lowest matching index.
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((perm_q[i] != 2'b00) &&
          (bus.ReqAddr >= base_q[i]) &&
          (bus.ReqAddr <= limit_q[i])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Offset test covers both stack bounds; addresses below STACK_LO wrap high.
  logic stack_hit;
  assign stack_hit = ((bus.ReqAddr - STACK_LO) <= STACK_SPAN) && (bus.ReqAddr < bus.SP);

  cause_e cause;
  always_comb begin
    cause = CAUSE_OK;
    if (stack_hit)                          cause = CAUSE_STACK;
    else if (!hit)                          cause = CAUSE_UNMAPPED;
    else if (!perm_q[hit_idx][bus.ReqWrite]) cause = CAUSE_PERM;
  end

  // Control FSM
  state_e state_q, state_d;
  logic   ready_q;
  logic   accept;
  logic   enter_fault;
  logic   ack_fault;

  assign accept = bus.ReqValid && ready_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    enter_fault = 1'b0;
    ack_fault   = 1'b0;
    case (state_q)
      RUN: begin
        if (accept && (cause != CAUSE_OK)) begin
          state_d     = FAULT;
          enter_fault = 1'b1;
        end
      end
      FAULT: begin
        if (FaultAck) begin
          state_d   = RUN;
          ack_fault = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Registered response and ready
  logic       resp_valid_q;
  logic       resp_fault_q;
  logic [1:0] resp_cause_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= CAUSE_OK;
    end else begin
      ready_q      <= (state_d == RUN);
      resp_valid_q <= accept;
      resp_fault_q <= accept && (cause != CAUSE_OK);
      resp_cause_q <= accept ? cause : CAUSE_OK;
    end
  end

  assign bus.ReqReady  = ready_q;
  assign bus.RespValid = resp_valid_q;
  assign bus.RespFault = resp_fault_q;
  assign bus.RespCause = resp_cause_q;

  // Sticky fault record; address and cause survive the acknowledge.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      FaultPending <= 1'b0;
      FaultAddr    <= '0;
      FaultCause   <= CAUSE_OK;
    end else if (enter_fault) begin
      FaultPending <= 1'b1;
      FaultAddr    <= bus.ReqAddr;
      FaultCause   <= cause;
    end else if (ack_fault) begin
      FaultPending <= 1'b0;
    end
  end

`ifdef MPU_FAULT_COUNT_EN
  logic [7:0] fault_count_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      fault_count_q <= 8'd0;
    end else if (enter_fault && (fault_count_q != 8'hFF)) begin
      fault_count_q <= fault_count_q + 8'd1;
    end
  end

  assign FaultCount = fault_count_q;
`endif

endmodule
